// File: rtl/text_ram_arbiter.sv
// Round-robin arbiter sharing one line-wide text RAM port between several requesters,
// with one transaction in flight and an optional per-requester lock for atomic RMW.
`ifndef TEXT_RAM_LINE_WIDTH
`define TEXT_RAM_LINE_WIDTH 32
`endif

module text_ram_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 8,
  parameter int LINE_WIDTH   = `TEXT_RAM_LINE_WIDTH,
  parameter int READ_LATENCY = 2,
  parameter int LOCK_TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wren,
  input  logic [NUM_REQ-1:0]               req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [LINE_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            ram_address,
  output logic                             ram_wren,
  output logic [LINE_WIDTH-1:0]            ram_data,
  input  logic [LINE_WIDTH-1:0]            ram_q,
  output logic                             locked,
  output logic                             lock_timeout
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int TMO_W  = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      cur_q, cur_d;
  logic                  cur_wren_q, cur_wren_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic                  locked_q, locked_d;
  logic [TMO_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic                  ram_wren_q, ram_wren_d;
  logic [LINE_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  lock_timeout_q, lock_timeout_d;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [LINE_WIDTH-1:0] data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [IDX_W-1:0]      win;
  logic                  timeout_fire;
  logic                  lock_active;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = req_data[g*LINE_WIDTH +: LINE_WIDTH];
  end

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    if (v == LAST_IDX) return '0;
    return v + IDX_W'(1);
  endfunction

  // A lock that times out this cycle no longer restricts who may win this cycle.
  always_comb begin
    timeout_fire = (state_q == IDLE) && locked_q && !req_valid[owner_q] &&
                   (idle_cnt_q == TMO_LAST);
    lock_active  = locked_q && !timeout_fire;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (!lock_active || (IDX_W'(i) == owner_q));
    end
  end

  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    win   = '0;
    cand  = last_grant_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_inc(cand);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_q   <= LAST_IDX;
      cur_q          <= '0;
      cur_wren_q     <= 1'b0;
      owner_q        <= '0;
      locked_q       <= 1'b0;
      idle_cnt_q     <= '0;
      wait_cnt_q     <= '0;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      ram_address_q  <= '0;
      ram_wren_q     <= 1'b0;
      ram_data_q     <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cur_q          <= cur_d;
      cur_wren_q     <= cur_wren_d;
      owner_q        <= owner_d;
      locked_q       <= locked_d;
      idle_cnt_q     <= idle_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      ram_address_q  <= ram_address_d;
      ram_wren_q     <= ram_wren_d;
      ram_data_q     <= ram_data_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (found) state_d = ISSUE;
      ISSUE: state_d = cur_wren_q ? IDLE : WAIT;
      WAIT:  if (wait_cnt_q == '0) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pulse outputs default low; ISSUE-cycle outputs are registered from the IDLE decision.
  always_comb begin
    last_grant_d   = last_grant_q;
    cur_d          = cur_q;
    cur_wren_d     = cur_wren_q;
    owner_d        = owner_q;
    locked_d       = locked_q;
    idle_cnt_d     = idle_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    req_ready_d    = '0;
    rsp_valid_d    = '0;
    rsp_data_d     = rsp_data_q;
    ram_address_d  = ram_address_q;
    ram_wren_d     = 1'b0;
    ram_data_d     = ram_data_q;
    lock_timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!locked_q) begin
          idle_cnt_d = '0;
        end else if (timeout_fire) begin
          locked_d       = 1'b0;
          lock_timeout_d = 1'b1;
          idle_cnt_d     = '0;
        end else if (!req_valid[owner_q]) begin
          idle_cnt_d = idle_cnt_q + TMO_W'(1);
        end
        if (found) begin
          req_ready_d[win] = 1'b1;
          ram_address_d    = addr_arr[win];
          ram_data_d       = data_arr[win];
          ram_wren_d       = req_wren[win];
          last_grant_d     = win;
          cur_d            = win;
          cur_wren_d       = req_wren[win];
          locked_d         = req_lock[win];
          idle_cnt_d       = '0;
          if (req_lock[win]) owner_d = win;
        end
      end
      ISSUE: begin
        if (!cur_wren_q) wait_cnt_d = WAIT_LOAD;
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          rsp_data_d         = ram_q;
          rsp_valid_d[cur_q] = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign ram_address  = ram_address_q;
  assign ram_wren     = ram_wren_q;
  assign ram_data     = ram_data_q;
  assign locked       = locked_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Scoreboard bench for text_ram_arbiter: directed requests with hand-computed grants and
// read responses, a RAM model with two-cycle read latency, and a decoupled output monitor.
module tb_text_ram_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int LW = 32;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_wren, req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*LW-1:0] req_data;
  logic [NR-1:0] req_ready, rsp_valid;
  logic [LW-1:0] rsp_data, ram_data, ram_q;
  logic [AW-1:0] ram_address;
  logic          ram_wren, locked, lock_timeout;

  text_ram_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .READ_LATENCY(RL), .LOCK_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wren(req_wren), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
    .locked(locked), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: address registered into a two-stage read pipe
  bit          init_done = 1'b0;
  logic [LW-1:0] mem [256];
  logic [LW-1:0] qp0, qp1;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int a = 0; a < 256; a++) mem[a] <= 32'hA500_0000 | 32'(a);
      init_done <= 1'b1;
    end else if (ram_wren) begin
      mem[ram_address] <= ram_data;
    end
    qp0 <= mem[ram_address];
    qp1 <= qp0;
  end
  assign ram_q = qp1;

  typedef struct {
    logic          wren;
    logic          lock;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    int            dly;
  } req_t;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic          wren;
    logic [LW-1:0] data;
    logic          lkd;
    logic          tmo;
    int            gap;
  } gexp_t;

  typedef struct {
    int            idx;
    logic [LW-1:0] data;
    logic          lkd;
  } rexp_t;

  req_t  pend [NR][$];
  int    dly_cnt [NR];
  gexp_t gq [$];
  rexp_t rq [$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    tmo_seen = 0;
  int    gcyc [NR];
  int    last_rsp_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input int idx, input logic wren, input logic lock, input logic [AW-1:0] addr,
                     input logic [LW-1:0] data, input int dly, input logic lkd,
                     input logic tmo, input int gap);
    req_t  r;
    gexp_t g;
    r.wren = wren; r.lock = lock; r.addr = addr; r.data = data; r.dly = dly;
    pend[idx].push_back(r);
    g.idx = idx; g.addr = addr; g.wren = wren; g.data = data; g.lkd = lkd; g.tmo = tmo; g.gap = gap;
    gq.push_back(g);
  endtask

  task automatic expect_rsp(input int idx, input logic [LW-1:0] data, input logic lkd);
    rexp_t r;
    r.idx = idx; r.data = data; r.lkd = lkd;
    rq.push_back(r);
  endtask

  task automatic monitor();
    gexp_t g;
    rexp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < NR; i++) begin
          if (req_ready[2'(i)]) begin
            if (gq.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL grant_unexpected: requester %0d got ready, none expected", i);
            end else begin
              g = gq.pop_front();
              chk("grant_idx", 64'(i), 64'(g.idx));
              chk("grant_addr", 64'(ram_address), 64'(g.addr));
              chk("grant_wren", 64'(ram_wren), 64'(g.wren));
              chk("grant_data", 64'(ram_data), 64'(g.data));
              chk("grant_locked", 64'(locked), 64'(g.lkd));
              chk("grant_lock_timeout", 64'(lock_timeout), 64'(g.tmo));
              if (g.gap >= 0) chk("grant_gap_after_rsp", 64'(cyc - last_rsp_cyc), 64'(g.gap));
              gcyc[i] = cyc;
            end
          end
          if (rsp_valid[2'(i)]) begin
            if (rq.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL rsp_unexpected: requester %0d got rsp_valid, none expected", i);
            end else begin
              r = rq.pop_front();
              chk("rsp_idx", 64'(i), 64'(r.idx));
              chk("rsp_data", 64'(rsp_data), 64'(r.data));
              chk("rsp_locked", 64'(locked), 64'(r.lkd));
              chk("rsp_latency", 64'(cyc - gcyc[i]), 64'(RL + 1));
            end
            last_rsp_cyc = cyc;
          end
        end
        if (ram_wren && (req_ready == '0)) begin
          n_chk++; n_fail++;
          $display("FAIL wren_without_grant: ram_wren=1 with req_ready=0");
        end
        if (lock_timeout) tmo_seen++;
      end
    end
  endtask

  // Presents each requester's queued request, holds it until ready, then moves on.
  task automatic run(input int max_cyc);
    int n;
    bit busy;
    n = 0;
    forever begin
      busy = 1'b0;
      for (int i = 0; i < NR; i++) begin
        req_valid[2'(i)] = 1'b0;
        if (pend[i].size() > 0) begin
          busy = 1'b1;
          if (dly_cnt[i] >= pend[i][0].dly) begin
            req_valid[2'(i)]       = 1'b1;
            req_wren[2'(i)]        = pend[i][0].wren;
            req_lock[2'(i)]        = pend[i][0].lock;
            req_addr[i*AW +: AW]   = pend[i][0].addr;
            req_data[i*LW +: LW]   = pend[i][0].data;
          end else begin
            dly_cnt[i]++;
          end
        end
      end
      if (!busy) break;
      if (n >= max_cyc) begin
        n_chk++; n_fail++;
        $display("FAIL run_timeout: requests still pending after %0d cycles", n);
        for (int i = 0; i < NR; i++) begin pend[i].delete(); dly_cnt[i] = 0; end
        req_valid = '0;
        break;
      end
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < NR; i++) begin
        if (req_valid[2'(i)] && req_ready[2'(i)]) begin
          void'(pend[i].pop_front());
          dly_cnt[i] = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_wren = '0; req_lock = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin dly_cnt[i] = 0; gcyc[i] = 0; end
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulses", 64'({req_ready, rsp_valid, ram_wren, lock_timeout}), 64'd0);
    chk("reset_ram_address", 64'(ram_address), 64'd0);
    chk("reset_ram_data", 64'(ram_data), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_locked", 64'(locked), 64'd0);
    rst = 1'b1;
    idle(2);

    // Round-robin with all three writing back-to-back
    add(0, 1'b1, 1'b0, 8'h20, 32'h0000_0020, 0, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b0, 8'h21, 32'h1111_0021, 0, 1'b0, 1'b0, -1);
    add(2, 1'b1, 1'b0, 8'h22, 32'h2222_0022, 0, 1'b0, 1'b0, -1);
    add(0, 1'b1, 1'b0, 8'h23, 32'h0000_0023, 0, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b0, 8'h24, 32'h1111_0024, 0, 1'b0, 1'b0, -1);
    add(2, 1'b1, 1'b0, 8'h25, 32'h2222_0025, 0, 1'b0, 1'b0, -1);
    run(40);
    idle(4);

    // Single write by requester 1
    add(1, 1'b1, 1'b0, 8'h05, 32'hDEAD_0005, 0, 1'b0, 1'b0, -1);
    run(10);
    idle(6);

    // Single read by requester 0 of an untouched line
    add(0, 1'b0, 1'b0, 8'h10, 32'h0, 0, 1'b0, 1'b0, -1);
    expect_rsp(0, 32'hA500_0010, 1'b0);
    run(10);
    idle(8);

    // Locked read-modify-write by requester 0 while requester 2 waits
    add(0, 1'b0, 1'b1, 8'h03, 32'h0, 0, 1'b1, 1'b0, -1);
    expect_rsp(0, 32'hA500_0003, 1'b1);
    add(0, 1'b1, 1'b0, 8'h03, 32'h5A5A_0003, 0, 1'b0, 1'b0, -1);
    add(2, 1'b1, 1'b0, 8'h07, 32'h2222_0007, 2, 1'b0, 1'b0, -1);
    run(40);
    idle(6);

    // Lock owner 1 goes quiet; forced release lets requester 0 in 16 cycles after the response
    add(1, 1'b0, 1'b1, 8'h05, 32'h0, 0, 1'b1, 1'b0, -1);
    expect_rsp(1, 32'hDEAD_0005, 1'b1);
    add(0, 1'b1, 1'b0, 8'h30, 32'h3030_3030, 3, 1'b0, 1'b1, 16);
    run(60);
    idle(8);
    chk("lock_timeout_pulses", 64'(tmo_seen), 64'd1);

    // Reset while a read is waiting on the RAM
    add(0, 1'b0, 1'b0, 8'h10, 32'h0, 0, 1'b0, 1'b0, -1);
    run(10);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midreset_pulses", 64'({req_ready, rsp_valid, ram_wren, lock_timeout}), 64'd0);
    chk("midreset_ram_address", 64'(ram_address), 64'd0);
    chk("midreset_rsp_data", 64'(rsp_data), 64'd0);
    chk("midreset_locked", 64'(locked), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(8);
    add(0, 1'b1, 1'b0, 8'h40, 32'h0000_0040, 0, 1'b0, 1'b0, -1);
    add(1, 1'b1, 1'b0, 8'h41, 32'h1111_0041, 0, 1'b0, 1'b0, -1);
    add(2, 1'b1, 1'b0, 8'h42, 32'h2222_0042, 0, 1'b0, 1'b0, -1);
    run(30);
    idle(6);

    chk("grants_outstanding", 64'(gq.size()), 64'd0);
    chk("responses_outstanding", 64'(rq.size()), 64'd0);
    chk("lock_timeout_pulses_total", 64'(tmo_seen), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/text_ram_arbiter.md
Name: text_ram_arbiter

Overview:
- Shares the single line-wide text RAM port (one line per address, 1-cycle write, fixed read latency) between NUM_REQ requesters: parser text editor, scroll/erase engine, renderer prefetch.
- Round-robin arbitration with one transaction in flight.
- Optional per-requester lock keeps read-modify-write sequences atomic.
- Sits between the parser-side engines and the text RAM macro.

Parameters:
NUM_REQ, 3, number of requesters (index 0..NUM_REQ-1)
ADDR_WIDTH, 8, RAM line address width
LINE_WIDTH, `TEXT_RAM_LINE_WIDTH, bits per RAM line
READ_LATENCY, 2, cycles from ram_address presented to ram_q valid (>=1)
LOCK_TIMEOUT, 15, idle cycles a lock owner may hold the port before forced release

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  request pending, one bit per requester
req_wren  in  NUM_REQ  1 = write, 0 = read
req_lock  in  NUM_REQ  keep ownership after this transaction
req_addr  in  NUM_REQ*ADDR_WIDTH  line address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  in  NUM_REQ*LINE_WIDTH  write data, same packing
req_ready  out  NUM_REQ  one-cycle accept pulse
rsp_valid  out  NUM_REQ  one-cycle read-data-valid pulse
rsp_data  out  LINE_WIDTH  read data, shared by all requesters
ram_address  out  ADDR_WIDTH  to RAM
ram_wren  out  1  to RAM
ram_data  out  LINE_WIDTH  to RAM
ram_q  in  LINE_WIDTH  from RAM
locked  out  1  a lock is held
lock_timeout  out  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0. Lock cleared. RR pointer last_grant = NUM_REQ-1, so requester 0 has first priority. A transaction in flight is aborted and produces no rsp_valid.
- States:
  - IDLE: sample req_valid in cycle T. Eligible requesters are all valid requesters, or only the owner when locked. Winner is the first eligible index after last_grant, cyclically. If any winner exists, go to ISSUE.
  - ISSUE (T+1): ram_address/ram_data = winner's addr/data; ram_wren = winner's wren; req_ready[winner] = 1; last_grant = winner. Write: go to IDLE. Read: go to WAIT.
  - WAIT: counts READ_LATENCY-1 cycles. ram_wren = 0, ram_address held. At the end of cycle T+1+READ_LATENCY, capture ram_q into rsp_data and go to RESP.
  - RESP (T+2+READ_LATENCY): rsp_valid[winner] = 1 for one cycle; go to IDLE.
- Latency:
  - Write: accepted and performed in T+1.
  - Read: data in T+4 for READ_LATENCY=2.
  - Back-to-back: next request sampled in the first IDLE cycle after ISSUE (write) or RESP (read).
- Handshake:
  - Requester holds valid/wren/lock/addr/data stable until it sees req_ready.
  - Requester drops or changes valid in the cycle after ready. Arbiter ignores req_* in ISSUE, WAIT and RESP.
  - Valid withdrawn before sampling is not an error.
- req_ready, rsp_valid, ram_wren and lock_timeout are registered pulses, never high more than one cycle per transaction.
- ram_address, ram_data and rsp_data hold their last value between transactions.
- Lock:
  - Captured at ISSUE. lock=1 sets owner = winner and locked = 1. A transaction by the owner with lock=0 clears locked at its ISSUE.
  - While locked, other requesters' valid are ignored and they keep waiting.
- Lock timeout: idle counter counts IDLE cycles while locked with the owner's req_valid low; reset on each owner grant. Reaching LOCK_TIMEOUT clears locked and pulses lock_timeout for one cycle. That IDLE cycle arbitrates normally.
- Simultaneous requests: round-robin. With all NUM_REQ=3 valid continuously, grants go 0,1,2,0...
- Address is passed through unchanged; no range check.

Test Plan:
- Single write: req 1 valid, wren=1, addr=0x05, data=D, sampled at T -> ram_wren=1, ram_address=0x05, ram_data=D, req_ready[1]=1, all in T+1 only. No rsp_valid.
- Single read, READ_LATENCY=2: req 0 reads addr 0x10, RAM model returns Q at T+3 -> rsp_valid[0]=1 and rsp_data=Q at T+4. ram_wren=0 throughout.
- Round-robin: reqs 0,1,2 all valid, each drops after ready and re-asserts next cycle, all writes -> grant order 0,1,2,0,1,2. No requester granted twice consecutively.
- Lock RMW: req 0 reads 0x03 with lock=1, req 2 valid meanwhile, req 0 then writes 0x03 with lock=0 -> req 2 granted only after req 0's write ISSUE. locked=1 from the read ISSUE until the write ISSUE.
- Lock timeout: req 1 reads with lock=1 then goes idle, req 0 waiting -> after 15 idle cycles lock_timeout pulses, locked=0, req 0 granted next.
- Reset mid-read: rst low during WAIT -> all outputs 0 immediately. No rsp_valid after release. First post-reset grant with all valid goes to requester 0.
